rgbw_sbit2wrd: RTL

//  Assembles WS2812b-style serial bits into NUM_CHAN x CHAN_BITS pixel words, for RGB or RGBW.

---
 rtl/rgbw_sbit2wrd.sv | 119 +++++++++++
 1 files changed

// File: rtl/rgbw_sbit2wrd.sv
// rtl/rgbw_sbit2wrd.sv - serial bit to pixel word assembler with output FIFO
// Optional pixel counter enabled by defining RGBW_SBIT2WRD_PIXCNT_EN.
module rgbw_sbit2wrd #(
    parameter int NUM_CHAN   = 3,
    parameter int CHAN_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            strobe,
    input  logic                            sbit_value,
    input  logic                            stream_reset,
    output logic [NUM_CHAN*CHAN_BITS+7:0]   out_word,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            overflow
`ifdef RGBW_SBIT2WRD_PIXCNT_EN
    ,
    output logic [15:0]                     pix_count
`endif
);
    localparam int DATA_W = NUM_CHAN * CHAN_BITS;
    localparam int WORD_W = DATA_W + 8;
    localparam int BC_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [BC_W-1:0] TOP = BC_W'(DATA_W - 1);

    logic [BC_W-1:0]   bcount;
    logic [DATA_W-1:0] shreg;
    logic              strobe_seen;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_next;
    logic [CNT_W-1:0]  count, count_next;

    logic              ev, ev_bit, ev_sr, last_bit, push_req, push, pop, full;
    logic [BC_W-1:0]   bit_pos;
    logic [DATA_W-1:0] data_next;
    logic [WORD_W-1:0] push_word;

    always_comb begin
        ev        = strobe && !strobe_seen;
        ev_bit    = ev && !stream_reset;
        ev_sr     = ev && stream_reset;
        last_bit  = (bcount == TOP);
        bit_pos   = (MSB_FIRST != 0) ? (TOP - bcount) : bcount;
        data_next = shreg;
        if (ev_bit) begin
            data_next[bit_pos] = sbit_value;
        end
        push_req = ev_sr || (ev_bit && last_bit);
        if (ev_sr) begin
            push_word = (bcount == '0) ? {8'hC0, {DATA_W{1'b0}}} : {8'hE0, shreg};
        end else begin
            push_word = {8'h80, data_next};
        end
        full       = (count == CNT_W'(FIFO_DEPTH));
        out_valid  = (count != '0);
        pop        = out_valid && out_ready;
        push       = push_req && (!full || pop);
        rd_next    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Storage array carries no reset; only pointers define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_seen <= 1'b0;
            bcount      <= '0;
            shreg       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            out_word    <= '0;
            overflow    <= 1'b0;
        end else begin
            strobe_seen <= strobe;
            if (push_req) begin
                bcount <= '0;
                shreg  <= '0;
            end else if (ev_bit) begin
                bcount <= bcount + BC_W'(1);
                shreg  <= data_next;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            // The head register bypasses the array when the new head is being written now.
            if (count_next != '0) begin
                out_word <= (push && (wr_ptr == rd_next)) ? push_word : mem[rd_next];
            end
        end
    end

`ifdef RGBW_SBIT2WRD_PIXCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_count <= '0;
        end else if (ev_sr) begin
            pix_count <= '0;
        end else if (ev_bit && last_bit && (pix_count != 16'hFFFF)) begin
            pix_count <= pix_count + 16'd1;
        end
    end
`endif

endmodule
